bcd_serial_calc: RTL and testbench

- Parametrised, digit-serial BCD add/subtract calculator for DIGITS-digit unsigned operands. Processes one BCD digit per clock.
- Subtraction returns sign plus magnitude: a second recomplement pass runs when a borrow occurs.
- Drives per-digit registered 7-segment patterns for the display board and flags non-BCD input digits.
- Successor to the fixed 4-digit combinational adder/LED path.

---
 rtl/bcd_serial_calc_pkg.sv | 41 ++++
 rtl/bcd_seg7_dec.sv | 35 +++
 rtl/bcd_serial_calc.sv | 187 ++++++++++++++++++
 tb/tb_bcd_serial_calc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_calc_pkg.sv
// ============================================================================
// Module      : bcd_serial_calc_pkg
// Description : Shared FSM encoding and seven-segment constants for the
//               digit-serial BCD calculator.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bcd_serial_calc_pkg;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC = 3'd1;
  localparam logic [2:0] ST_ADD_ENC  = 3'd2;
  localparam logic [2:0] ST_FIX_ENC  = 3'd3;
  localparam logic [2:0] ST_DONE_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_LOAD = ST_LOAD_ENC,
    ST_ADD  = ST_ADD_ENC,
    ST_FIX  = ST_FIX_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

`default_nettype wire

// File: rtl/bcd_seg7_dec.sv
// ============================================================================
// Module      : bcd_seg7_dec
// Description : Combinational BCD digit to seven-segment pattern decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd_seg7_dec
  import bcd_serial_calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_calc.sv
// ============================================================================
// Module      : bcd_serial_calc
// Description : Digit-serial BCD add/subtract with sign-magnitude result,
//               input digit checking and registered 7-segment outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd_serial_calc
  import bcd_serial_calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  neg,
  output logic                  err,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W  = 4 * DIGITS;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_mode;
  logic [IW-1:0]   r_idx;
  logic            r_carry;

  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [3:0]      w_r_dig;
  logic [3:0]      w_op_a;
  logic [3:0]      w_op_b;
  logic [4:0]      w_sum;
  logic [3:0]      w_digit;
  logic            w_carry;
  logic            w_last;
  logic            w_bad;
  logic [W-1:0]    w_result_nx;
  logic [7*DIGITS-1:0] w_seg;

  // Shared BCD digit adder: ADD uses a_i + b'_i, FIX recomplements r_i
  always_comb begin
    w_a_dig = r_a[{r_idx, 2'b00} +: 4];
    w_b_dig = r_b[{r_idx, 2'b00} +: 4];
    w_r_dig = result[{r_idx, 2'b00} +: 4];
    if (r_state == ST_FIX) begin
      w_op_a = 4'd9 - w_r_dig;
      w_op_b = 4'd0;
    end else begin
      w_op_a = w_a_dig;
      w_op_b = r_mode ? (4'd9 - w_b_dig) : w_b_dig;
    end
    w_sum = {1'b0, w_op_a} + {1'b0, w_op_b} + {4'b0000, r_carry};
    if (w_sum > 5'd9) begin
      w_digit = w_sum[3:0] + 4'd6;
      w_carry = 1'b1;
    end else begin
      w_digit = w_sum[3:0];
      w_carry = 1'b0;
    end
    w_last = (r_idx == IW'(DIGITS - 1));
  end

  always_comb begin
    w_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((r_a[4*k +: 4] > 4'd9) || (r_b[4*k +: 4] > 4'd9)) begin
        w_bad = 1'b1;
      end
    end
  end

  // Next-state view of result so seg can be registered alongside done
  always_comb begin
    w_result_nx = result;
    case (r_state)
      ST_LOAD:         w_result_nx = '0;
      ST_ADD, ST_FIX:  w_result_nx[{r_idx, 2'b00} +: 4] = w_digit;
      default:         w_result_nx = result;
    endcase
  end

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_seg7_dec u_dec (
        .bcd (w_result_nx[4*g +: 4]),
        .seg (w_seg[7*g +: 7])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      neg     <= 1'b0;
      err     <= 1'b0;
      seg     <= {DIGITS{SEG_0}};
    end else begin
      done   <= 1'b0;
      result <= w_result_nx;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            busy    <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_idx   <= '0;
          r_carry <= r_mode;
          cout    <= 1'b0;
          neg     <= 1'b0;
          err     <= w_bad;
          if (w_bad) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            seg     <= w_seg;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_idx   <= r_idx + 1'b1;
          r_carry <= w_carry;
          if (w_last) begin
            if (r_mode && !w_carry) begin
              neg     <= 1'b1;
              r_idx   <= '0;
              r_carry <= 1'b1;
              r_state <= ST_FIX;
            end else begin
              cout    <= r_mode ? 1'b0 : w_carry;
              busy    <= 1'b0;
              done    <= 1'b1;
              seg     <= w_seg;
              r_state <= ST_DONE;
            end
          end
        end
        ST_FIX: begin
          r_idx   <= r_idx + 1'b1;
          r_carry <= w_carry;
          if (w_last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            seg     <= w_seg;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_calc.sv
// ============================================================================
// Module      : tb_bcd_serial_calc
// Description : Self-checking bench for bcd_serial_calc (DIGITS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_serial_calc;

  localparam int D = 4;

  typedef struct {
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_r;
    logic        exp_cout;
    logic        exp_neg;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        neg;
  logic        err;
  logic [27:0] seg;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  vec_t sb_q[$];
  vec_t tbl[10];

  bcd_serial_calc #(.DIGITS(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .neg    (neg),
    .err    (err),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [27:0] seg_exp(input logic [15:0] r);
    logic [27:0] s;
    for (int i = 0; i < D; i++) s[7*i +: 7] = seg_of(r[4*i +: 4]);
    return s;
  endfunction

  task automatic issue(input vec_t v);
    @(negedge clk);
    start = 1'b1; mode = v.mode; a = v.a; b = v.b;
    sb_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc0: cycles already elapsed since the start cycle at the current negedge
  task automatic collect(input int cyc0, input string tag);
    int   cyc;
    int   exp_lat;
    vec_t v;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s timeout: done not seen after %0d cycles, expected a done pulse", tag, cyc);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: done with empty queue, expected a pending op", tag);
      return;
    end
    v = sb_q.pop_front();
    exp_lat = v.exp_err ? 2 : (v.exp_neg ? 2*D + 2 : D + 2);
    check({tag, " result"}, 64'(result), 64'(v.exp_r));
    check({tag, " cout"},   64'(cout),   64'(v.exp_cout));
    check({tag, " neg"},    64'(neg),    64'(v.exp_neg));
    check({tag, " err"},    64'(err),    64'(v.exp_err));
    check({tag, " busy@done"}, 64'(busy), 64'(0));
    check({tag, " seg"},    64'(seg),    64'(seg_exp(v.exp_r)));
    check({tag, " latency"}, 64'(cyc),   64'(exp_lat));
    @(negedge clk);
    check({tag, " done pulse width"}, 64'(done), 64'(0));
  endtask

  task automatic run_op(input vec_t v, input string tag);
    issue(v);
    check({tag, " busy@load"}, 64'(busy), 64'(1));
    collect(1, tag);
  endtask

  initial begin
    int lat;
    int n0;
    vec_t v;

    tbl[0] = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'h5000, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 16'h0000, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("reset busy",   64'(busy),   64'(0));
    check("reset done",   64'(done),   64'(0));
    check("reset result", 64'(result), 64'(0));
    check("reset flags",  64'({cout, neg, err}), 64'(0));
    check("reset seg",    64'(seg),    64'({4{7'h3F}}));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // start pulses while busy must be ignored
    n0 = done_cnt;
    issue(tbl[2]);
    start = 1'b1; mode = 1'b0; a = 16'h9999; b = 16'h9999;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    collect(3, "busy-start");
    repeat (10) @(negedge clk);
    check("busy-start done count", 64'(done_cnt - n0), 64'(1));

    // start held high: back-to-back operations
    n0 = done_cnt;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 16'h0011; b = 16'h0022;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      lat = 1;
      while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
      check($sformatf("held op%0d latency", k), 64'(lat), 64'(k == 0 ? D + 2 : D + 3));
      check($sformatf("held op%0d result", k),  64'(result), 64'(16'h0033));
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("held done count", 64'(done_cnt - n0), 64'(2));

    // reset in the middle of ADD aborts with no done
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 16'h6666; b = 16'h6666;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort busy",   64'(busy),   64'(0));
    check("abort done",   64'(done),   64'(0));
    check("abort result", 64'(result), 64'(0));
    check("abort flags",  64'({cout, neg, err}), 64'(0));
    check("abort seg",    64'(seg),    64'({4{7'h3F}}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort no done", 64'(done_cnt - n0), 64'(0));
    v = '{1'b0, 16'h0050, 16'h0050, 16'h0100, 1'b0, 1'b0, 1'b0};
    run_op(v, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
